// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and the decode-facing head.
// The master modport is the fetch queue itself; the slave modport is its environment.
interface ifetch_queue_if #(
  parameter int XLEN       = 64,
  parameter int IMEM_WORDS = 1024,
  parameter int QDEPTH     = 4
) ();
  localparam int AW = $clog2(IMEM_WORDS);
  localparam int OW = $clog2(QDEPTH) + 1;

  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            ifid_valid;
  logic [31:0]     ifid_ir;
  logic [XLEN-1:0] ifid_pc;
  logic [OW-1:0]   occupancy;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  id_ready,
    input  redirect_valid,
    input  redirect_pc,
    output ifid_valid,
    output ifid_ir,
    output ifid_pc,
    output occupancy
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output id_ready,
    output redirect_valid,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_ir,
    input  ifid_pc,
    input  occupancy
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage with a prefetch FIFO feeding the IF/ID register via valid/ready.
// Optional performance counters are enabled with the IFQ_STATS_EN macro.
module ifetch_queue #(
  parameter int              XLEN       = 64,
  parameter int              IMEM_WORDS = 1024,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
  input logic           clock,
  input logic           reset,
  ifetch_queue_if.master bus
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_flush_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam int PW = $clog2(QDEPTH);
  localparam int OW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [XLEN-1:0] pc_mem_q [QDEPTH];
  logic [XLEN-1:0] pc_mem_d [QDEPTH];
  logic [31:0]     ir_mem_q [QDEPTH];
  logic [31:0]     ir_mem_d [QDEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OW'(QDEPTH));
  assign pop   = !empty && bus.id_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push  = !bus.redirect_valid && (!full || pop);

  assign bus.imem_addr = fetch_pc_q[AW+1:2];

  // Head outputs come only from storage, never from imem_rdata.
  assign bus.ifid_valid = !empty;
  assign bus.ifid_ir    = empty ? NOP_INSTR : ir_mem_q[rd_ptr_q];
  assign bus.ifid_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign bus.occupancy  = occ_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      pc_mem_d[i] = pc_mem_q[i];
      ir_mem_d[i] = ir_mem_q[i];
    end
    if (push) begin
      pc_mem_d[wr_ptr_q] = fetch_pc_q;
      ir_mem_d[wr_ptr_q] = bus.imem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Entry storage needs no reset: the occupancy count gates every read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < QDEPTH; i++) begin
      pc_mem_q[i] <= pc_mem_d[i];
      ir_mem_q[i] <= ir_mem_d[i];
    end
  end

`ifdef IFQ_STATS_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(push);
    perf_flush_d = perf_flush_q + 32'(bus.redirect_valid);
    perf_stall_d = perf_stall_q + 32'(!empty && !bus.id_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  a_occ_bound: assert property (@(posedge clock) disable iff (reset) occ_q <= OW'(QDEPTH));
  a_ptr_gap: assert property (@(posedge clock) disable iff (reset)
    (wr_ptr_q - rd_ptr_q) == occ_q[PW-1:0]);

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a reference model of the queue predicts every head word.
// Defining IFQ_STATS_EN also checks the performance counters.
module tb_ifetch_queue;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ir;
  } entry_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] imem [1024];
  entry_t      model_q[$];
  logic [63:0] model_pc;
  int unsigned m_fetch, m_flush, m_stall;

  ifetch_queue_if #(.XLEN(64), .IMEM_WORDS(1024), .QDEPTH(4)) bus ();
  ifetch_queue_if #(.XLEN(64), .IMEM_WORDS(1024), .QDEPTH(4)) wbus ();

`ifdef IFQ_STATS_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
  logic [31:0] w_fetch, w_flush, w_stall;
`endif

  ifetch_queue #(.XLEN(64), .IMEM_WORDS(1024), .QDEPTH(4), .RESET_PC(64'h0)) dut (
    .clock (clock),
    .reset (rst),
    .bus   (bus)
`ifdef IFQ_STATS_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  ifetch_queue #(.XLEN(64), .IMEM_WORDS(1024), .QDEPTH(4), .RESET_PC(64'hFFC)) dut_wrap (
    .clock (clock),
    .reset (rst),
    .bus   (wbus)
`ifdef IFQ_STATS_EN
    ,
    .perf_fetch_cnt (w_fetch),
    .perf_flush_cnt (w_flush),
    .perf_stall_cnt (w_stall)
`endif
  );

  always #5 clock = ~clock;

  assign bus.imem_rdata  = imem[bus.imem_addr];
  assign wbus.imem_rdata = imem[wbus.imem_addr];
  assign wbus.id_ready       = 1'b1;
  assign wbus.redirect_valid = 1'b0;
  assign wbus.redirect_pc    = '0;

  // Advance one clock, updating the reference model with the inputs currently driven.
  task automatic tick();
    bit pop_m, push_m;
    entry_t e;
    pop_m  = (model_q.size() != 0) && bus.id_ready;
    push_m = !bus.redirect_valid && ((model_q.size() < 4) || pop_m);
    if (rst) begin
      model_q.delete();
      model_pc = 64'h0;
      m_fetch = 0; m_flush = 0; m_stall = 0;
    end else begin
      if (push_m) m_fetch++;
      if (bus.redirect_valid) m_flush++;
      if ((model_q.size() != 0) && !bus.id_ready) m_stall++;
      if (bus.redirect_valid) begin
        model_q.delete();
        model_pc = {bus.redirect_pc[63:2], 2'b00};
      end else begin
        if (pop_m) void'(model_q.pop_front());
        if (push_m) begin
          e.pc = model_pc;
          e.ir = imem[model_pc[11:2]];
          model_q.push_back(e);
          model_pc = model_pc + 64'd4;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.ifid_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.ifid_valid); end
    checks++; if (bus.ifid_ir !== 32'h13) begin failures++; $display("[TB] FAIL reset_ir got=%h exp=00000013", bus.ifid_ir); end
    checks++; if (bus.ifid_pc !== 64'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.ifid_pc); end
    checks++; if (bus.occupancy !== 3'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.imem_addr !== 10'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d exp=0", bus.imem_addr); end
  endtask

  task automatic test_ramp();
    entry_t exp;
    rst = 1'b0;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = model_q[0];
      checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== exp.pc || bus.ifid_ir !== exp.ir) begin
        failures++; $display("[TB] FAIL ramp_head%0d got=%0b/%h/%h exp=1/%h/%h", i, bus.ifid_valid, bus.ifid_pc, bus.ifid_ir, exp.pc, exp.ir);
      end
      checks++; if (bus.ifid_pc !== 64'(4 * i) || bus.ifid_ir !== 32'(32'h100 + i)) begin
        failures++; $display("[TB] FAIL ramp_const%0d got=%h/%h exp=%h/%h", i, bus.ifid_pc, bus.ifid_ir, 4 * i, 32'h100 + i);
      end
      checks++; if (bus.occupancy !== 3'd1) begin failures++; $display("[TB] FAIL ramp_occ%0d got=%0d exp=1", i, bus.occupancy); end
    end
  endtask

  task automatic test_backpressure();
    entry_t exp;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.id_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (bus.occupancy !== 3'((i > 4) ? 4 : i)) begin
        failures++; $display("[TB] FAIL bp_occ%0d got=%0d exp=%0d", i, bus.occupancy, (i > 4) ? 4 : i);
      end
    end
    checks++; if (bus.imem_addr !== 10'd4) begin failures++; $display("[TB] FAIL bp_addr_hold got=%0d exp=4", bus.imem_addr); end
`ifdef IFQ_STATS_EN
    checks++; if (perf_stall_cnt !== 32'(m_stall)) begin failures++; $display("[TB] FAIL bp_stall_cnt got=%0d exp=%0d", perf_stall_cnt, m_stall); end
    checks++; if (perf_fetch_cnt !== 32'(m_fetch)) begin failures++; $display("[TB] FAIL bp_fetch_cnt got=%0d exp=%0d", perf_fetch_cnt, m_fetch); end
`endif
    bus.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = model_q[0];
      checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== exp.pc || bus.ifid_pc !== 64'(4 * i) || bus.ifid_ir !== exp.ir) begin
        failures++; $display("[TB] FAIL bp_drain%0d got=%0b/%h/%h exp=1/%h/%h", i, bus.ifid_valid, bus.ifid_pc, bus.ifid_ir, exp.pc, exp.ir);
      end
      tick();
      checks++; if (bus.occupancy !== 3'd4) begin failures++; $display("[TB] FAIL bp_full_occ%0d got=%0d exp=4", i, bus.occupancy); end
    end
  endtask

  task automatic test_redirect();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.id_ready = 1'b0;
    repeat (3) tick();
    checks++; if (bus.occupancy !== 3'd3) begin failures++; $display("[TB] FAIL redir_pre_occ got=%0d exp=3", bus.occupancy); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h42;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.occupancy !== 3'd0 || bus.ifid_valid !== 1'b0 || bus.ifid_ir !== 32'h13) begin
      failures++; $display("[TB] FAIL redir_bubble got=%0d/%0b/%h exp=0/0/00000013", bus.occupancy, bus.ifid_valid, bus.ifid_ir);
    end
    checks++; if (bus.imem_addr !== 10'h10) begin failures++; $display("[TB] FAIL redir_addr got=%0d exp=16", bus.imem_addr); end
    tick();
    checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 64'h40 || bus.ifid_ir !== imem[16]) begin
      failures++; $display("[TB] FAIL redir_target got=%0b/%h/%h exp=1/40/%h", bus.ifid_valid, bus.ifid_pc, bus.ifid_ir, imem[16]);
    end
  endtask

  task automatic test_redirect_pop();
    entry_t exp;
    logic [31:0] stall_before;
    bus.id_ready = 1'b1;
    tick(); tick();
    stall_before = 32'(m_stall);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h201;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_ir !== 32'h13) begin
      failures++; $display("[TB] FAIL rpop_bubble got=%0b/%h exp=0/00000013", bus.ifid_valid, bus.ifid_ir);
    end
    tick();
    checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 64'h200 || bus.ifid_ir !== 32'h180) begin
      failures++; $display("[TB] FAIL rpop_target got=%0b/%h/%h exp=1/200/00000180", bus.ifid_valid, bus.ifid_pc, bus.ifid_ir);
    end
    tick();
    exp = model_q[0];
    checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== exp.pc || bus.ifid_ir !== exp.ir) begin
      failures++; $display("[TB] FAIL rpop_next got=%0b/%h/%h exp=1/%h/%h", bus.ifid_valid, bus.ifid_pc, bus.ifid_ir, exp.pc, exp.ir);
    end
`ifdef IFQ_STATS_EN
    checks++; if (perf_stall_cnt !== stall_before) begin failures++; $display("[TB] FAIL rpop_stall got=%0d exp=%0d", perf_stall_cnt, stall_before); end
    checks++; if (perf_flush_cnt !== 32'(m_flush)) begin failures++; $display("[TB] FAIL rpop_flush got=%0d exp=%0d", perf_flush_cnt, m_flush); end
`else
    stall_before = '0;
`endif
  endtask

  task automatic test_back_to_back();
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h80;
    tick();
    bus.redirect_pc = 64'hC4;
    tick();
    checks++; if (bus.ifid_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_bubble got=%0b exp=0", bus.ifid_valid); end
    bus.redirect_valid = 1'b0;
    tick();
    checks++; if (bus.ifid_pc !== 64'hC4 || bus.ifid_ir !== 32'h131 || bus.ifid_pc !== model_q[0].pc) begin
      failures++; $display("[TB] FAIL b2b_target got=%h/%h exp=c4/00000131", bus.ifid_pc, bus.ifid_ir);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (wbus.imem_addr !== 10'd1023 || wbus.ifid_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL wrap_start got=%0d/%0b exp=1023/0", wbus.imem_addr, wbus.ifid_valid);
    end
    tick();
    checks++; if (wbus.ifid_pc !== 64'hFFC || wbus.ifid_ir !== 32'h4FF || wbus.imem_addr !== 10'd0) begin
      failures++; $display("[TB] FAIL wrap_last got=%h/%h/%0d exp=ffc/000004ff/0", wbus.ifid_pc, wbus.ifid_ir, wbus.imem_addr);
    end
    tick();
    checks++; if (wbus.ifid_pc !== 64'h1000 || wbus.ifid_ir !== 32'h100 || wbus.imem_addr !== 10'd1) begin
      failures++; $display("[TB] FAIL wrap_first got=%h/%h/%0d exp=1000/00000100/1", wbus.ifid_pc, wbus.ifid_ir, wbus.imem_addr);
    end
  endtask

  task automatic test_reset_midrun();
    bus.id_ready = 1'b0;
    repeat (5) tick();
    checks++; if (bus.occupancy !== 3'd4) begin failures++; $display("[TB] FAIL mid_full got=%0d exp=4", bus.occupancy); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.occupancy !== 3'd0 || bus.ifid_valid !== 1'b0 || bus.ifid_ir !== 32'h13 || bus.ifid_pc !== 64'h0) begin
      failures++; $display("[TB] FAIL mid_reset got=%0d/%0b/%h/%h exp=0/0/00000013/0", bus.occupancy, bus.ifid_valid, bus.ifid_ir, bus.ifid_pc);
    end
    checks++; if (bus.imem_addr !== 10'd0) begin failures++; $display("[TB] FAIL mid_addr got=%0d exp=0", bus.imem_addr); end
`ifdef IFQ_STATS_EN
    checks++; if (perf_fetch_cnt !== 0 || perf_flush_cnt !== 0 || perf_stall_cnt !== 0) begin
      failures++; $display("[TB] FAIL mid_perf got=%0d/%0d/%0d exp=0/0/0", perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt);
    end
`endif
    tick();
    checks++; if (bus.ifid_pc !== 64'h0 || bus.ifid_ir !== 32'h100 || bus.ifid_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_head got=%0b/%h/%h exp=1/0/00000100", bus.ifid_valid, bus.ifid_pc, bus.ifid_ir);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h100 + 32'(i);
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    model_pc = 64'h0;
    m_fetch = 0; m_flush = 0; m_stall = 0;
    @(negedge clock);
    test_reset();
    test_ramp();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
